ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
Parametrised next-generation execute stage with the EX/MEM pipeline register built in.
- Adds operand forwarding from the MEM and WB stages.
- Adds an iterative multi-cycle multiplier (R-type funct 0x18) that stalls upstream while it runs.
- Adds stall and flush control of the EX/MEM register.
- Sits between the ID/EX register and the MEM stage of the pipelined CPU.

Parameters:
XLEN, 32, datapath width in bits (>=8)
REGW, 5, register-index width
FWD_EN, 1, 1 enables forwarding muxes; 0 passes rs_val/rt_val straight through

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ID/EX slot holds a real instruction
mem_stall  in  1  MEM stage cannot accept; EX/MEM register and FSM hold
flush  in  1  squash current EX instruction (branch taken)
pc_4  in  XLEN  PC+4 of instruction
rs_val, rt_val  in  XLEN  register-file operands
sign_ext  in  XLEN  sign-extended immediate; [5:0] is funct
rs_addr  in  REGW  source index rs
instr20_16  in  REGW  rt index; I-type destination
instr15_11  in  REGW  rd index; R-type destination
wb  in  2  [1]=RegWrite, [0]=MemToReg
mem  in  3  MEM-stage controls, passed through
aluop  in  2  00 add, 01 sub, 10 R-type by funct, 11 or
alusrc  in  1  1 selects sign_ext as B
regdst  in  1  1 selects instr15_11 as destination
fwd_mem_we, fwd_wb_we  in  1  RegWrite of the instruction in MEM / WB
fwd_mem_dst, fwd_wb_dst  in  REGW  destination of that instruction
fwd_mem_data, fwd_wb_data  in  XLEN  value to forward
busy  out  1  combinational; upstream must hold ID/EX while high
out_valid  out  1  EX/MEM slot valid
wbEX  out  2  registered wb (zeroed for bubbles)
memEX  out  3  registered mem (zeroed for bubbles)
brDst  out  XLEN  registered pc_4 + (sign_ext<<2), modulo 2^XLEN
zFlag  out  1  registered (result == 0)
alu_out  out  XLEN  registered result
rtEX  out  XLEN  registered forwarded rt value (store data)
wrDstEX  out  REGW  registered destination index

Behaviour:
- Reset: all registered outputs are 0, the FSM is IDLE, and the counter is 0.
- Forwarding (rs and rt each):
  - MEM source wins when fwd_mem_we=1, fwd_mem_dst != 0 and fwd_mem_dst matches the index.
  - Otherwise the WB source is used under the same rule.
  - Otherwise the register-file value is used.
  - Index 0 is never forwarded.
- ALU, single-cycle operations: add, sub, and (0x24), or (0x25), slt (0x2A, signed, result 0/1).
  - R-type funct 0x20 is add and 0x22 is sub.
  - Any other funct yields add.
  - All arithmetic is truncated to XLEN bits.
- Single-cycle latency: the result appears on the EX/MEM outputs on the edge after acceptance.
- Multiply: aluop=10 with funct=0x18.
  - FSM states: IDLE, MUL, DONE.
  - IDLE->MUL when in_valid, mult and no flush. At that point the forwarded operands are captured, busy=1, and a bubble is loaded into EX/MEM.
  - MUL is one shift-add step per cycle for XLEN cycles, with busy=1 throughout.
  - MUL->DONE after XLEN steps.
  - In DONE, busy=0 and the low XLEN bits of the product load into EX/MEM. Then DONE->IDLE.
  - Total latency is XLEN+1 cycles. zFlag reflects the product.
- Bubbles: out_valid=0 and wbEX=memEX=0. Data outputs are don't-care but are driven with 0.
- mem_stall=1: the EX/MEM register holds, the FSM and counter freeze, and busy=1.
- flush=1:
  - A bubble loads into EX/MEM and the FSM returns to IDLE, aborting any multiply.
  - flush has priority over mem_stall.
- rst has priority over everything, including mid-multiply.
- in_valid=0 loads a bubble.

Decomposition:
- Shared package ex_pkg holds:
  - ALUOP_ADD/SUB/RTYPE/OR
  - FUNCT_ADD/SUB/AND/OR/SLT/MULT
  - the state enum IDLE/MUL/DONE
  - ALU control codes
- One sub-module, iter_mult: start/done handshake, XLEN-parameterised shift-add with stall freeze and abort.

Test Plan:
- R-type add, rs=5, rt=7, funct 0x20, regdst=1, rd=3: next cycle alu_out=12, wrDstEX=3, zFlag=0, out_valid=1.
- beq-style sub, rs=rt=0x10, aluop=01, pc_4=0x100, sign_ext=4: zFlag=1 and brDst=0x110.
- Forwarding priority, rs_addr=2, fwd_mem (we=1, dst=2, 9), fwd_wb (we=1, dst=2, 4): A=9. With dst=0, rs_val is used.
- Multiply 6×7 (XLEN=32): busy high for 32 cycles with bubbles output; alu_out=42 at cycle 33. 0xFFFFFFFF×2 gives 0xFFFFFFFE.
- flush at multiply cycle 10: next cycle out_valid=0, busy=0, FSM IDLE. A following add completes normally.
- mem_stall for 3 cycles mid-multiply: outputs are held and completion is delayed by exactly 3 cycles. rst mid-multiply zeroes all outputs the next edge.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the multi-cycle execute stage: ALU opcodes, funct codes, FSM states.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: ALUOP_* encodings, FUNCT_* codes, state_e, alu_ctl_e, alu_decode().
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctl_e;

  // Unknown R-type functs fall back to add; multiply is handled outside the ALU.
  function automatic alu_ctl_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_ctl_e c;
    c = ALU_ADD;
    case (aluop)
      ALUOP_ADD: c = ALU_ADD;
      ALUOP_SUB: c = ALU_SUB;
      ALUOP_OR:  c = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: c = ALU_ADD;
          FUNCT_SUB: c = ALU_SUB;
          FUNCT_AND: c = ALU_AND;
          FUNCT_OR:  c = ALU_OR;
          FUNCT_SLT: c = ALU_SLT;
          default:   c = ALU_ADD;
        endcase
      end
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_stage_mc_iter_mult.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// Latency: XLEN step cycles after start; last is high during the final step.
// Backpressure: steps only when step=1 (frozen otherwise); abort clears the step counter.
// Ports: clk, rst, start (load a/b), step, abort, a, b, last, product.
module iter_mult #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] product
);
  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      // Only the low XLEN product bits are kept, so the shifted-out
      // multiplicand bits never matter.
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign last    = (cnt == CW'(XLEN - 1));
  assign product = acc;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with forwarding, single-cycle ALU, iterative multiplier and EX/MEM register.
// Latency: 1 cycle for ALU ops, XLEN+1 cycles for multiply (funct 0x18).
// Backpressure: busy holds ID/EX upstream; mem_stall freezes EX/MEM and FSM; flush wins over stall.
// Ports: clk/rst, ID/EX fields (in_valid, pc_4, rs_val, rt_val, sign_ext, indices, wb/mem/alu ctl),
//        forwarding sources (fwd_mem_*, fwd_wb_*), busy, and the registered EX/MEM outputs.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            mem_stall,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_4,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [XLEN-1:0] sign_ext,
  input  logic [REGW-1:0] rs_addr,
  input  logic [REGW-1:0] instr20_16,
  input  logic [REGW-1:0] instr15_11,
  input  logic [1:0]      wb,
  input  logic [2:0]      mem,
  input  logic [1:0]      aluop,
  input  logic            alusrc,
  input  logic            regdst,
  input  logic            fwd_mem_we,
  input  logic            fwd_wb_we,
  input  logic [REGW-1:0] fwd_mem_dst,
  input  logic [REGW-1:0] fwd_wb_dst,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            busy,
  output logic            out_valid,
  output logic [1:0]      wbEX,
  output logic [2:0]      memEX,
  output logic [XLEN-1:0] brDst,
  output logic            zFlag,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] rtEX,
  output logic [REGW-1:0] wrDstEX
);

  state_e          state, state_nxt;
  alu_ctl_e        alu_ctl;
  logic [XLEN-1:0] a_op, rt_op, b_op, alu_res, mul_prod, ex_res, rt_hold;
  logic [REGW-1:0] dst;
  logic            is_mult, mul_start, mul_step, mul_last;
  logic            ld_en, ld_valid, use_mul;

  // MEM beats WB; register 0 is hard-wired and never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGW-1:0] idx,  input logic [XLEN-1:0] rf,
    input logic            m_we, input logic [REGW-1:0] m_dst, input logic [XLEN-1:0] m_dat,
    input logic            w_we, input logic [REGW-1:0] w_dst, input logic [XLEN-1:0] w_dat);
    logic [XLEN-1:0] v;
    v = rf;
    if (FWD_EN != 0 && idx != '0) begin
      if (m_we && m_dst == idx)      v = m_dat;
      else if (w_we && w_dst == idx) v = w_dat;
    end
    return v;
  endfunction

  assign a_op  = fwd_sel(rs_addr, rs_val, fwd_mem_we, fwd_mem_dst, fwd_mem_data,
                         fwd_wb_we, fwd_wb_dst, fwd_wb_data);
  assign rt_op = fwd_sel(instr20_16, rt_val, fwd_mem_we, fwd_mem_dst, fwd_mem_data,
                         fwd_wb_we, fwd_wb_dst, fwd_wb_data);
  assign b_op    = alusrc ? sign_ext : rt_op;
  assign dst     = regdst ? instr15_11 : instr20_16;
  assign is_mult = (aluop == ALUOP_RTYPE) && (sign_ext[5:0] == FUNCT_MULT);
  assign alu_ctl = alu_decode(aluop, sign_ext[5:0]);

  always_comb begin
    alu_res = a_op + b_op;
    case (alu_ctl)
      ALU_SUB: alu_res = a_op - b_op;
      ALU_AND: alu_res = a_op & b_op;
      ALU_OR:  alu_res = a_op | b_op;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
      default: alu_res = a_op + b_op;
    endcase
  end

  iter_mult #(.XLEN(XLEN)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step    (mul_step),
    .abort   (flush),
    .a       (a_op),
    .b       (b_op),
    .last    (mul_last),
    .product (mul_prod)
  );

  always_comb begin
    state_nxt = state;
    busy      = mem_stall;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && !mem_stall && in_valid && is_mult) begin
          state_nxt = MUL;
          mul_start = 1'b1;
        end
        // A multiply already in ID/EX must be held even on the cycle it is accepted.
        if (!flush && in_valid && is_mult) busy = 1'b1;
      end
      MUL: begin
        busy = 1'b1;
        if (!flush && !mem_stall) begin
          mul_step = 1'b1;
          if (mul_last) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!flush && !mem_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // In DONE the ID/EX fields (pc_4, sign_ext, wb, mem, dst) are still the
  // multiply's because busy held them; only forwarded values can have moved,
  // so the operands and rt were captured at start.
  assign ld_en    = flush || !mem_stall;
  assign use_mul  = (state == DONE);
  assign ld_valid = !flush && ((state == IDLE && in_valid && !is_mult) || state == DONE);
  assign ex_res   = use_mul ? mul_prod : alu_res;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)            rt_hold <= '0;
    else if (mul_start) rt_hold <= rt_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      wbEX      <= '0;
      memEX     <= '0;
      brDst     <= '0;
      zFlag     <= 1'b0;
      alu_out   <= '0;
      rtEX      <= '0;
      wrDstEX   <= '0;
    end else if (ld_en) begin
      if (ld_valid) begin
        out_valid <= 1'b1;
        wbEX      <= wb;
        memEX     <= mem;
        brDst     <= pc_4 + (sign_ext << 2);
        zFlag     <= (ex_res == '0);
        alu_out   <= ex_res;
        rtEX      <= use_mul ? rt_hold : rt_op;
        wrDstEX   <= dst;
      end else begin
        out_valid <= 1'b0;
        wbEX      <= '0;
        memEX     <= '0;
        brDst     <= '0;
        zFlag     <= 1'b0;
        alu_out   <= '0;
        rtEX      <= '0;
        wrDstEX   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model (pending multiply with a step count).
module tb_ex_stage_mc;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk;
  logic            rst, in_valid, mem_stall, flush;
  logic [XLEN-1:0] pc_4, rs_val, rt_val, sign_ext;
  logic [REGW-1:0] rs_addr, instr20_16, instr15_11;
  logic [1:0]      wb, aluop;
  logic [2:0]      mem;
  logic            alusrc, regdst;
  logic            fwd_mem_we, fwd_wb_we;
  logic [REGW-1:0] fwd_mem_dst, fwd_wb_dst;
  logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
  logic            busy, out_valid, zFlag;
  logic [1:0]      wbEX;
  logic [2:0]      memEX;
  logic [XLEN-1:0] brDst, alu_out, rtEX;
  logic [REGW-1:0] wrDstEX;

  ex_stage_mc #(.XLEN(XLEN), .REGW(REGW), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_stall(mem_stall), .flush(flush),
    .pc_4(pc_4), .rs_val(rs_val), .rt_val(rt_val), .sign_ext(sign_ext),
    .rs_addr(rs_addr), .instr20_16(instr20_16), .instr15_11(instr15_11),
    .wb(wb), .mem(mem), .aluop(aluop), .alusrc(alusrc), .regdst(regdst),
    .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
    .fwd_mem_dst(fwd_mem_dst), .fwd_wb_dst(fwd_wb_dst),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .busy(busy), .out_valid(out_valid), .wbEX(wbEX), .memEX(memEX), .brDst(brDst),
    .zFlag(zFlag), .alu_out(alu_out), .rtEX(rtEX), .wrDstEX(wrDstEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit busy_seen;

  // Expected EX/MEM contents.
  logic            e_valid, e_z;
  logic [1:0]      e_wb;
  logic [2:0]      e_mem;
  logic [XLEN-1:0] e_br, e_alu, e_rt;
  logic [REGW-1:0] e_dst;

  // Pending multiply: everything it will write, plus how many steps have elapsed.
  bit              m_active;
  int              m_steps;
  logic [XLEN-1:0] m_prod, m_rt, m_br;
  logic [1:0]      m_wb;
  logic [2:0]      m_mem;
  logic [REGW-1:0] m_dst;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] mfwd(input logic [REGW-1:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 0) return rf;
    if (fwd_mem_we && fwd_mem_dst == idx) return fwd_mem_data;
    if (fwd_wb_we && fwd_wb_dst == idx) return fwd_wb_data;
    return rf;
  endfunction

  function automatic logic [XLEN-1:0] malu(input logic [1:0] op, input logic [5:0] f,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (op == 2'b01) return a - b;
    if (op == 2'b11) return a | b;
    if (op == 2'b10) begin
      if (f == 6'h22) return a - b;
      if (f == 6'h24) return a & b;
      if (f == 6'h25) return a | b;
      if (f == 6'h2A) return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
    end
    return a + b;
  endfunction

  function automatic bit is_mul();
    return (aluop == 2'b10) && (sign_ext[5:0] == 6'h18);
  endfunction

  function automatic bit model_busy();
    return mem_stall || (m_active && m_steps < XLEN) || (!m_active && in_valid && is_mul() && !flush);
  endfunction

  task automatic set_exp(input logic v, input logic [1:0] w, input logic [2:0] m, input logic [XLEN-1:0] br,
                         input logic [XLEN-1:0] r, input logic [XLEN-1:0] rt, input logic [REGW-1:0] d);
    e_valid = v; e_wb = w; e_mem = m; e_br = br; e_alu = r; e_z = v && (r == 0); e_rt = rt; e_dst = d;
  endtask

  task automatic model_edge();
    logic [XLEN-1:0] a, rtf, b;
    logic [REGW-1:0] d;
    a   = mfwd(rs_addr, rs_val);
    rtf = mfwd(instr20_16, rt_val);
    b   = alusrc ? sign_ext : rtf;
    d   = regdst ? instr15_11 : instr20_16;
    if (rst) begin
      set_exp(0, 0, 0, 0, 0, 0, 0); m_active = 0;
    end else if (flush) begin
      set_exp(0, 0, 0, 0, 0, 0, 0); m_active = 0;
    end else if (mem_stall) begin
      // EX/MEM and the multiply in progress simply hold.
    end else if (!m_active) begin
      if (in_valid && is_mul()) begin
        m_active = 1; m_steps = 0; m_prod = a * b; m_rt = rtf;
        m_br = pc_4 + sign_ext * 4; m_wb = wb; m_mem = mem; m_dst = d;
        set_exp(0, 0, 0, 0, 0, 0, 0);
      end else if (in_valid) begin
        set_exp(1, wb, mem, pc_4 + sign_ext * 4, malu(aluop, sign_ext[5:0], a, b), rtf, d);
      end else begin
        set_exp(0, 0, 0, 0, 0, 0, 0);
      end
    end else if (m_steps < XLEN) begin
      m_steps++;
      set_exp(0, 0, 0, 0, 0, 0, 0);
    end else begin
      set_exp(1, m_wb, m_mem, m_br, m_prod, m_rt, m_dst);
      m_active = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    busy_seen = busy;
    if (!rst) chk("busy", 32'(busy), 32'(model_busy()));
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("wbEX", 32'(wbEX), 32'(e_wb));
    chk("memEX", 32'(memEX), 32'(e_mem));
    chk("brDst", brDst, e_br);
    chk("zFlag", 32'(zFlag), 32'(e_z));
    chk("alu_out", alu_out, e_alu);
    chk("rtEX", rtEX, e_rt);
    chk("wrDstEX", 32'(wrDstEX), 32'(e_dst));
    @(negedge clk);
  endtask

  task automatic clr();
    rst = 0; in_valid = 0; mem_stall = 0; flush = 0; pc_4 = 0; rs_val = 0; rt_val = 0;
    sign_ext = 0; rs_addr = 0; instr20_16 = 0; instr15_11 = 0; wb = 0; mem = 0; aluop = 0;
    alusrc = 0; regdst = 0; fwd_mem_we = 0; fwd_wb_we = 0; fwd_mem_dst = 0; fwd_wb_dst = 0;
    fwd_mem_data = 0; fwd_wb_data = 0;
  endtask

  task automatic mul_setup(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    clr(); in_valid = 1; aluop = 2'b10; sign_ext = 32'h18; rs_addr = 1; instr20_16 = 2;
    instr15_11 = 4; regdst = 1; wb = 2'b10; pc_4 = 32'h40; rs_val = a; rt_val = b;
  endtask

  // Accepts a multiply, then steps until out_valid; lat counts cycles after acceptance.
  task automatic run_mult(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int st_at,
                          input int st_n, output int lat, output int bcnt);
    mul_setup(a, b);
    step();
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      mem_stall = (k >= st_at && k < st_at + st_n);
      step();
      if (busy_seen) bcnt++;
      if (out_valid === 1'b1) lat = k;
    end
    mem_stall = 0; in_valid = 0;
  endtask

  task automatic new_instr();
    logic [5:0] f;
    int kind;
    in_valid   = ($urandom_range(0, 7) != 0);
    kind       = $urandom_range(0, 11);
    aluop      = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25; 4: f = 6'h2A;
      default: f = 6'($urandom);
    endcase
    if (kind < 2) begin aluop = 2'b10; f = 6'h18; end
    sign_ext   = $urandom;
    sign_ext[5:0] = f;
    alusrc     = ($urandom_range(0, 3) == 0);
    regdst     = 1'($urandom);
    rs_addr    = REGW'($urandom_range(0, 3));
    instr20_16 = REGW'($urandom_range(0, 3));
    instr15_11 = REGW'($urandom);
    rs_val     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    rt_val     = ($urandom_range(0, 4) == 0) ? rs_val : $urandom;
    pc_4       = $urandom;
    wb         = 2'($urandom);
    mem        = 3'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, bcnt;
    bit hold, prev_kill;
    clr(); rst = 1;
    m_active = 0; m_steps = 0;
    @(negedge clk);
    step();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset alu_out", alu_out, 32'd0);
    step();
    rst = 0;
    step();
    chk("idle busy", 32'(busy_seen), 32'd0);

    // R-type add 5+7 into rd=3.
    clr(); in_valid = 1; aluop = 2'b10; sign_ext = 32'h20; rs_val = 5; rt_val = 7;
    regdst = 1; instr15_11 = 3; rs_addr = 1; instr20_16 = 2; wb = 2'b10; mem = 3'b001;
    step();
    chk("add alu_out", alu_out, 32'd12);
    chk("add wrDstEX", 32'(wrDstEX), 32'd3);
    chk("add zFlag", 32'(zFlag), 32'd0);
    chk("add out_valid", 32'(out_valid), 32'd1);

    // beq-style subtract and branch target.
    clr(); in_valid = 1; aluop = 2'b01; rs_val = 32'h10; rt_val = 32'h10; pc_4 = 32'h100;
    sign_ext = 4; rs_addr = 1; instr20_16 = 2;
    step();
    chk("beq zFlag", 32'(zFlag), 32'd1);
    chk("beq brDst", brDst, 32'h110);

    // Forwarding priority on rs.
    clr(); in_valid = 1; rs_addr = 2; rs_val = 1; instr20_16 = 5;
    fwd_mem_we = 1; fwd_mem_dst = 2; fwd_mem_data = 9;
    fwd_wb_we = 1; fwd_wb_dst = 2; fwd_wb_data = 4;
    step();
    chk("fwd mem wins", alu_out, 32'd9);
    fwd_mem_we = 0;
    step();
    chk("fwd wb", alu_out, 32'd4);
    fwd_mem_we = 1; rs_addr = 0; fwd_mem_dst = 0; fwd_wb_dst = 0;
    step();
    chk("fwd r0 blocked", alu_out, 32'd1);

    // Signed slt with rt forwarded from MEM (store data also forwarded).
    clr(); in_valid = 1; aluop = 2'b10; sign_ext = 32'h2A; rs_addr = 1; rs_val = 32'hFFFF_FFFF;
    instr20_16 = 3; rt_val = 100; fwd_mem_we = 1; fwd_mem_dst = 3; fwd_mem_data = 1;
    step();
    chk("slt signed", alu_out, 32'd1);
    chk("slt rtEX fwd", rtEX, 32'd1);

    // Multiplies.
    run_mult(6, 7, 0, 0, lat, bcnt);
    chk("mul 6x7 latency", 32'(lat), 32'(XLEN + 1));
    chk("mul 6x7 busy cycles", 32'(bcnt), 32'(XLEN));
    chk("mul 6x7 result", alu_out, 32'd42);
    step();
    run_mult(32'hFFFF_FFFF, 2, 0, 0, lat, bcnt);
    chk("mul ffffffff x2", alu_out, 32'hFFFF_FFFE);
    step();
    run_mult(13, 11, 10, 3, lat, bcnt);
    chk("mul stall latency", 32'(lat), 32'(XLEN + 4));
    chk("mul stall result", alu_out, 32'd143);
    step();

    // Flush at multiply cycle 10, then a normal add.
    mul_setup(3, 5);
    step();
    for (int k = 1; k < 10; k++) step();
    flush = 1;
    step();
    chk("flush out_valid", 32'(out_valid), 32'd0);
    clr();
    step();
    chk("flush then idle busy", 32'(busy_seen), 32'd0);
    in_valid = 1; rs_val = 3; rt_val = 4; rs_addr = 1; instr20_16 = 2;
    step();
    chk("add after flush", alu_out, 32'd7);

    // Reset mid-multiply.
    mul_setup(9, 9);
    step();
    for (int k = 1; k < 6; k++) step();
    rst = 1;
    step();
    chk("rst mid-mul out_valid", 32'(out_valid), 32'd0);
    chk("rst mid-mul alu_out", alu_out, 32'd0);
    clr();
    step();
    chk("rst mid-mul idle busy", 32'(busy_seen), 32'd0);

    // Randomized traffic; ID/EX holds its instruction while busy was seen.
    prev_kill = 1;
    for (int n = 0; n < 3000; n++) begin
      hold = busy_seen && !prev_kill;
      rst = ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 39) == 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      if (!hold) new_instr();
      fwd_mem_we   = 1'($urandom);
      fwd_wb_we    = 1'($urandom);
      fwd_mem_dst  = REGW'($urandom_range(0, 3));
      fwd_wb_dst   = REGW'($urandom_range(0, 3));
      fwd_mem_data = $urandom;
      fwd_wb_data  = $urandom;
      prev_kill = flush || rst;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
